// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the seq_mult shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Step-counter width for an arbitrary operand width (never below 1 bit).
    function automatic int cnt_w(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Datapath for seq_mult: operand magnitudes, add-shift accumulator and signed result fix-up.
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               finish_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [2*WIDTH-1:0] c_o,
    output logic               mplier_last_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] c_q, c_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_sum;

    // The most-negative operand negates to itself, which read as unsigned is 2^(WIDTH-1).
    assign a_mag   = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign b_mag   = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // True when the multiplier will be empty after this cycle's shift.
    assign mplier_last_o = (mplier_q[WIDTH-1:1] == '0);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        c_d      = c_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (step_i) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
        if (finish_i) begin
            c_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            c_q      <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            c_q      <= c_d;
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with valid/ready handshakes and signed/unsigned mode.
// Optional early termination when the multiplier runs out of set bits: SEQ_MULT_EARLY_TERM_EN.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] c_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            load;
    logic            step;
    logic            finish;
    logic            early_done;
    logic            mplier_last;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign early_done = mplier_last;
`else
    logic unused_mplier_last;
    assign unused_mplier_last = mplier_last;
    assign early_done         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step    = 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_CNT || early_done) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    seq_mult_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_i        (load),
        .step_i        (step),
        .finish_i      (finish),
        .a_i           (a_i),
        .b_i           (b_i),
        .signed_i      (signed_i),
        .c_o           (c_o),
        .mplier_last_o (mplier_last)
    );

endmodule

// File: tb/tb_seq_mult.sv
// Directed and exhaustive bench for seq_mult at WIDTH=4.
module tb_seq_mult;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       signed_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] c_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    seq_mult #(.WIDTH(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .signed_i    (signed_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .c_o         (c_o)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
        int sa;
        int sb;
        int p;
        sa = (s && a[3]) ? int'(a) - 16 : int'(a);
        sb = (s && b[3]) ? int'(b) - 16 : int'(b);
        p  = sa * sb;
        return p[7:0];
    endfunction

    function automatic int exp_lat(input logic [3:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [3:0] mag;
        int hi;
        mag = (s && b[3]) ? (~b + 4'd1) : b;
        hi  = 1;
        for (int i = 0; i < 4; i++) begin
            if (mag[i]) hi = i + 1;
        end
        return hi;
`else
        return (b == 4'd0 && s) ? 4 : 4;
`endif
    endfunction

    // One operation: accept, measure edges to out_valid, check product, stall, then drain.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [7:0] exp, input int stall, input string tag);
        int n;
        @(negedge clk_i);
        a_i = a; b_i = b; signed_i = s; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_lat"}, 16'(n), 16'(exp_lat(b, s)));
        check({tag, "_c"}, 16'(c_o), 16'(exp));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk_i); #1;
            check({tag, "_stall_c"}, 16'(c_o), 16'(exp));
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check({tag, "_rdy"}, 16'(in_ready_o), 16'd1);
        $display("op %s a=%h b=%h s=%0d c=%h lat=%0d", tag, a, b, s, c_o, n);
    endtask

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = '0; b_i = '0; signed_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", 16'(in_ready_o), 16'd1);
        check("rst_out_valid", 16'(out_valid_o), 16'd0);
        check("rst_c", 16'(c_o), 16'd0);
        rst_i = 1'b0;

        // Directed vectors with hand-computed products.
        do_op(4'hF, 4'hF, 1'b0, 8'hE1, 0, "uFF");
        do_op(4'h8, 4'h8, 1'b1, 8'h40, 0, "s88");
        do_op(4'hD, 4'h5, 1'b1, 8'hF1, 0, "sD5");
        do_op(4'hD, 4'h5, 1'b0, 8'h41, 0, "uD5");
        do_op(4'h9, 4'h0, 1'b0, 8'h00, 0, "u90");
        do_op(4'h7, 4'h1, 1'b0, 8'h07, 0, "u71");
        do_op(4'h3, 4'h4, 1'b0, 8'h0C, 0, "u34");
        do_op(4'h8, 4'h0, 1'b1, 8'h00, 0, "s80");

        // Backpressure: hold DONE for 6 cycles while in_valid_i pulses.
        @(negedge clk_i);
        a_i = 4'h2; b_i = 4'h3; signed_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid_o && n < 20) begin
                @(posedge clk_i); #1;
                n++;
            end
            check("bp_lat", 16'(n), 16'(exp_lat(4'h3, 1'b0)));
        end
        for (int i = 0; i < 6; i++) begin
            a_i = 4'hF; b_i = 4'hF; in_valid_i = (i % 2 == 0);
            @(posedge clk_i); #1;
            check("bp_valid", 16'(out_valid_o), 16'd1);
            check("bp_c", 16'(c_o), 16'h06);
            check("bp_in_ready", 16'(in_ready_o), 16'd0);
        end
        // Transfer with in_valid_i still high: must not be accepted on the same edge.
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        check("bp_xfer_ready", 16'(in_ready_o), 16'd1);
        check("bp_xfer_valid", 16'(out_valid_o), 16'd0);
        check("bp_hold_c", 16'(c_o), 16'h06);
        $display("op backpressure c=%h", c_o);

        // Reset in the middle of an operation.
        @(negedge clk_i);
        a_i = 4'h5; b_i = 4'h5; signed_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("mid_rst_ready", 16'(in_ready_o), 16'd1);
        check("mid_rst_valid", 16'(out_valid_o), 16'd0);
        check("mid_rst_c", 16'(c_o), 16'd0);
        $display("op mid-busy reset c=%h", c_o);
        do_op(4'h3, 4'h7, 1'b0, 8'h15, 0, "u37");

        // Exhaustive sweep against the behavioural model with random output stalls.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                logic [7:0] ab;
                ab = 8'(i);
                do_op(ab[7:4], ab[3:0], m[0], model(ab[7:4], ab[3:0], m[0]),
                      int'($urandom_range(0, 2)), m[0] ? "sw_s" : "sw_u");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised sequential shift-add multiplier. Successor to the team's fixed 4x4 combinational multiplier: generic operand width, per-operation signed/unsigned mode, valid/ready handshakes on both sides. Sits between operand-producing logic and result consumers where a wide combinational multiplier is too costly in area or timing.

Parameters:
WIDTH, 4, operand width in bits (>=2); product width is 2*WIDTH.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  multiplicand
b_i  input  WIDTH  multiplier
signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
out_valid_o  output  1  product valid
out_ready_i  input  1  consumer accepts product
c_o  output  2*WIDTH  product

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst_i high at an edge, any state including mid-operation): state IDLE, in_ready_o=1, out_valid_o=0, c_o=0, internal registers cleared. rst_i has priority over all other events.
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i at an edge, capture a_i, b_i, signed_i -> BUSY, count=0.
  - BUSY: in_ready_o=0, out_valid_o=0. One multiplier bit per cycle, count increments.
  - DONE: out_valid_o=1, in_ready_o=0. On out_ready_i at an edge -> IDLE.
- Inputs outside IDLE are ignored. No accept in the same cycle as a DONE->IDLE transfer.
- Datapath on capture:
  - Signed mode: take magnitudes |a|, |b| as WIDTH-bit unsigned values (most-negative value maps to 2^(WIDTH-1), which fits).
  - Record neg = sign(a) XOR sign(b). Unsigned mode: neg=0.
  - Registers: acc (2W)=0, mcand (2W)=|a| zero-extended, mplier (W)=|b|.
- Each BUSY edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1.
- Finish: the BUSY edge with count==WIDTH-1 loads c_o with the final accumulator, two's-complement negated if neg, and moves to DONE.
  - out_valid_o rises exactly WIDTH edges after the accept edge.
  - Throughput is one operation per WIDTH+2 cycles minimum.
- c_o holds its value from the load until the next result load or reset. It is stable throughout DONE regardless of out_ready_i.
- Arithmetic: exact. Unsigned range 0..(2^W-1)^2. Signed product of two W-bit values always fits in 2W bits, including (-2^(W-1))^2. No overflow flag.
- Zero operand: normal latency, c_o=0. Negated zero stays 0.

Optional Feature:
SEQ_MULT_EARLY_TERM_EN
- Defined: a BUSY edge also finishes when mplier after that edge's shift is zero. Latency = max(1, index of highest set bit of |b| + 1) edges. Result identical.
- Undefined: fixed latency of WIDTH edges for every operation.

Decomposition:
- Package seq_mult_pkg holds:
  - State encoding typedef (IDLE, BUSY, DONE).
  - Counter width constant CNT_W = $clog2(WIDTH).
- Natural sub-module seq_mult_dp:
  - Contains acc/mcand/mplier registers, magnitude/negate logic and the add-shift step.
  - Driven by load/step/finish strobes from the FSM in seq_mult.

Test Plan (WIDTH=4, SEQ_MULT_EARLY_TERM_EN undefined unless stated):
1. Unsigned a=4'hF, b=4'hF, signed_i=0 -> c_o=8'hE1 (225), out_valid_o rises 4 edges after accept.
2. Signed a=4'h8, b=4'h8 -> c_o=8'h40 (+64). Signed a=4'hD(-3), b=4'h5 -> c_o=8'hF1 (-15). Unsigned a=4'hD, b=4'h5 -> c_o=8'h41 (65).
3. Backpressure: out_ready_i low 6 cycles in DONE -> out_valid_o stays 1, c_o stable, in_ready_o 0, in_valid_i pulses ignored. Transfer on out_ready_i, then in_ready_o=1 next cycle.
4. Reset mid-BUSY: assert rst_i at count 2 -> next cycle IDLE, c_o=0, out_valid_o=0. New a=3, b=7 -> c_o=8'h15.
5. Zero: a=4'h9, b=0 unsigned -> c_o=0 after 4 edges. With SEQ_MULT_EARLY_TERM_EN: b=1 -> result after 1 edge; b=4'h4 -> 3 edges; b=0 -> 1 edge.
6. Random sweep of all 256 operand pairs x both modes, compared against a behavioural a*b model, with random out_ready_i stalls.
